uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 22 ++
 rtl/byte_fifo.sv | 69 ++++++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_arb_pkg
// Description : Shared definitions for the two-requester UART TX arbiter:
//               requester count, default per-requester FIFO depth, FIFO entry
//               width ({Last, Data}) and the arbiter FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    localparam int NUM_REQ            = 2;
    localparam int FIFO_DEPTH_DEFAULT = 4;
    localparam int ENTRY_W            = 9;   // {Last, Data[7:0]}

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_e;

endpackage : uart_arb_pkg
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Synchronous FIFO, DEPTH entries of WIDTH bits, with
//               full/empty flags and a one-entry-left flag. Head entry is
//               presented combinationally on rdata_o.
// Ports       : clk_i      - clock, rising edge
//               rst_ni     - asynchronous active-low reset (empties FIFO)
//               push_i     - write wdata_i (ignored when full)
//               wdata_i    - entry to write
//               pop_i      - discard head entry (ignored when empty)
//               rdata_o    - head entry
//               full_o     - DEPTH entries stored
//               empty_o    - no entries stored
//               one_left_o - exactly one entry stored
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             one_left_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_ONE   = (AW+1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      occ_w;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push_w;
    logic             do_pop_w;

    assign occ_w      = wr_ptr_q - rd_ptr_q;
    assign full_o     = (occ_w == C_DEPTH);
    assign empty_o    = (occ_w == '0);
    assign one_left_o = (occ_w == C_ONE);
    assign do_push_w  = push_i && !full_o;
    assign do_pop_w   = pop_i && !empty_o;
    assign rdata_o    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push_w) wr_ptr_q <= wr_ptr_q + C_ONE;
            if (do_pop_w)  rd_ptr_q <= rd_ptr_q + C_ONE;
        end
    end

    // Storage needs no reset: stale entries are unreachable once pointers clear.
    always_ff @(posedge clk_i) begin
        if (do_push_w) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule : byte_fifo
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Arbitrates two byte-stream requesters onto one UART
//               transmitter input. Each requester has its own FIFO; whole
//               packets (terminated by Last) are sent without interleaving,
//               with round-robin choice when both have data waiting.
// Ports       : Clock, Reset (async, active-low)
//               Req0Data/Req0Valid/Req0Last/Req0Ready - requester 0 push side
//               Req1Data/Req1Valid/Req1Last/Req1Ready - requester 1 push side
//               DataIn/DataInValid/DataInReady        - UART transmitter side
//               Grant - one-hot owner, Busy - activity indicator
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Req0Data,
    input  logic       Req0Valid,
    input  logic       Req0Last,
    output logic       Req0Ready,
    input  logic [7:0] Req1Data,
    input  logic       Req1Valid,
    input  logic       Req1Last,
    output logic       Req1Ready,
    output logic [7:0] DataIn,
    output logic       DataInValid,
    input  logic       DataInReady,
    output logic [1:0] Grant,
    output logic       Busy
);

    arb_state_e         state_q, state_d;
    logic               owner_q, owner_d;   // granted requester index
    logic               rr_q, rr_d;         // preferred requester on contention
    logic               rdy_en_q;           // holds Ready low until first edge out of reset

    logic [ENTRY_W-1:0] head0_w, head1_w, head_w;
    logic               full0_w, full1_w, empty0_w, empty1_w, one0_w, one1_w;
    logic               push0_w, push1_w, pop0_w, pop1_w, xfer_w;
    logic               own_empty_w, own_one_w, own_push_w;

    assign Req0Ready = rdy_en_q && !full0_w;
    assign Req1Ready = rdy_en_q && !full1_w;
    assign push0_w   = Req0Valid && Req0Ready;
    assign push1_w   = Req1Valid && Req1Ready;

    byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo0 (
        .clk_i      (Clock),
        .rst_ni     (Reset),
        .push_i     (push0_w),
        .wdata_i    ({Req0Last, Req0Data}),
        .pop_i      (pop0_w),
        .rdata_o    (head0_w),
        .full_o     (full0_w),
        .empty_o    (empty0_w),
        .one_left_o (one0_w)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo1 (
        .clk_i      (Clock),
        .rst_ni     (Reset),
        .push_i     (push1_w),
        .wdata_i    ({Req1Last, Req1Data}),
        .pop_i      (pop1_w),
        .rdata_o    (head1_w),
        .full_o     (full1_w),
        .empty_o    (empty1_w),
        .one_left_o (one1_w)
    );

    assign head_w      = owner_q ? head1_w  : head0_w;
    assign own_empty_w = owner_q ? empty1_w : empty0_w;
    assign own_one_w   = owner_q ? one1_w   : one0_w;
    assign own_push_w  = owner_q ? push1_w  : push0_w;

    assign DataInValid = (state_q == ST_SEND);
    assign DataIn      = DataInValid ? head_w[7:0] : 8'h00;
    assign xfer_w      = DataInValid && DataInReady;
    assign pop0_w      = xfer_w && !owner_q;
    assign pop1_w      = xfer_w && owner_q;
    assign Grant       = (state_q == ST_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
    assign Busy        = (state_q != ST_IDLE) || !empty0_w || !empty1_w;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            rr_q     <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            rdy_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty0_w && !empty1_w) begin
                    owner_d = rr_q;
                    state_d = ST_SEND;
                end else if (!empty0_w) begin
                    owner_d = 1'b0;
                    state_d = ST_SEND;
                end else if (!empty1_w) begin
                    owner_d = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer_w) begin
                    if (head_w[8]) begin
                        state_d = ST_IDLE;
                        rr_d    = !owner_q;
                    end else if (own_one_w && !own_push_w) begin
                        // Mid-packet underrun: keep ownership, stop presenting.
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!own_empty_w) state_d = ST_SEND;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule : uart_tx_arbiter
`default_nettype wire
